// File: rtl/deserializer_fsm.sv
// deserializer_fsm: collects LSB-first serial bits into a LENGTH-bit word.
//   i_clk        : clock, all state changes on rising edge
//   i_rst        : synchronous active-high reset (wins over i_en)
//   i_en         : clock enable, low freezes everything
//   i_din        : serial data bit
//   i_din_valid  : i_din carries a valid bit
//   o_ready      : a serial bit can be accepted this cycle
//   ov_dout      : last completed parallel word
//   o_dout_valid : ov_dout holds an unconsumed word
//   i_ready      : downstream takes ov_dout this cycle
module deserializer_fsm #(
  parameter int LENGTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [LENGTH-1:0] r_shreg;
  logic [LENGTH-1:0] r_dout;
  logic [LENGTH-1:0] w_word;
  logic              w_bit_xfer;
  logic              w_word_xfer;
  logic              w_last;

  // Handshake outputs come straight from the state register.
  assign o_ready      = (r_state != FULL);
  assign o_dout_valid = (r_state == FULL);
  assign ov_dout      = r_dout;

  assign w_bit_xfer  = i_en & i_din_valid & o_ready;
  assign w_word_xfer = i_en & o_dout_valid & i_ready;
  assign w_last      = (r_cnt == CW'(LENGTH - 1));

  // Partial word with the incoming bit dropped into its slot; on the last
  // bit this is the complete word, so it loads ov_dout directly.
  always_comb begin
    w_word        = r_shreg;
    w_word[r_cnt] = i_din;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_bit_xfer) w_next = SHIFT;
      SHIFT:   if (w_bit_xfer && w_last) w_next = FULL;
      FULL:    if (w_word_xfer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
    end else if (w_bit_xfer) begin
      if (w_last) begin
        r_dout  <= w_word;
        r_cnt   <= '0;
        r_shreg <= '0;
      end else begin
        r_shreg <= w_word;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

endmodule
